// File: rtl/pll_lock_reset_seq_pkg.sv
// pll_seq_pkg: shared state encoding, widths and limits for the PLL reset sequencer.
package pll_seq_pkg;

    localparam int SEQ_STATE_W     = 3;
    localparam int LOCK_LOSS_CNT_W = 8;

    localparam logic [LOCK_LOSS_CNT_W-1:0] LOCK_LOSS_MAX = 8'hFF;

    typedef enum logic [SEQ_STATE_W-1:0] {
        ST_POR       = 3'd0,
        ST_WAIT_LOCK = 3'd1,
        ST_STABLE    = 3'd2,
        ST_HOLD      = 3'd3,
        ST_RUN       = 3'd4,
        ST_FAULT     = 3'd5
    } seq_state_e;

    function automatic int unsigned max2(
        input int unsigned a,
        input int unsigned b
    );
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/pll_lock_reset_seq_if.sv
// pll_seq_if: sequencer-side view of the PLL lock/reset handshake and status.
interface pll_seq_if;
    import pll_seq_pkg::*;

    logic                       lock;
    logic                       areset;
    logic                       soc_rst_n;
    logic [SEQ_STATE_W-1:0]     state;
    logic [LOCK_LOSS_CNT_W-1:0] loss_cnt;
    logic                       fault;

    modport master (
        input  lock,
        output areset,
        output soc_rst_n,
        output state,
        output loss_cnt,
        output fault
    );

    modport slave (
        output lock,
        input  areset,
        input  soc_rst_n,
        input  state,
        input  loss_cnt,
        input  fault
    );

endinterface

// File: rtl/pll_lock_reset_seq_fsm.sv
// Sequencing FSM with retry and lock-loss counters; all outputs registered.
// PLL_SEQ_LOCK_LOSS_CNT_EN builds the lock-loss counter, otherwise it reads 0.
module pll_lock_reset_seq_fsm #(
    parameter int unsigned POR_CYCLES          = 128,
    parameter int unsigned LOCK_TIMEOUT_CYCLES = 65536,
    parameter int unsigned LOCK_STABLE_CYCLES  = 1024,
    parameter int unsigned SOC_HOLD_CYCLES     = 16,
    parameter int unsigned MAX_RETRIES         = 3
) (
    input logic       clk_i,
    input logic       rst_ni,
    pll_seq_if.master ctl
);
    import pll_seq_pkg::*;

    localparam int unsigned CNT_MAX = max2(
        max2(POR_CYCLES, LOCK_TIMEOUT_CYCLES),
        max2(LOCK_STABLE_CYCLES, SOC_HOLD_CYCLES));
    localparam int CNT_W = $clog2(CNT_MAX + 1);

    seq_state_e       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [3:0]       retry_q, retry_d, retry_inc;
    logic             areset_q, areset_d;
    logic             soc_rst_n_q, soc_rst_n_d;
    logic             fault_q, fault_d;
    logic             por_done, timeout, stable_done, hold_done;

    assign por_done    = cnt_q == CNT_W'(POR_CYCLES - 1);
    assign timeout     = cnt_q == CNT_W'(LOCK_TIMEOUT_CYCLES - 1);
    assign stable_done = cnt_q == CNT_W'(LOCK_STABLE_CYCLES - 1);
    assign hold_done   = cnt_q == CNT_W'(SOC_HOLD_CYCLES - 1);
    assign retry_inc   = retry_q + 4'd1;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= ST_POR;
        end else begin
            state_q <= state_d;
        end
    end

    // Lock is checked before the timeout, so a simultaneous lock wins.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_POR: begin
                if (por_done) state_d = ST_WAIT_LOCK;
            end
            ST_WAIT_LOCK: begin
                if (ctl.lock) begin
                    state_d = ST_STABLE;
                end else if (timeout) begin
                    state_d = (retry_inc == 4'(MAX_RETRIES))
                            ? ST_FAULT : ST_POR;
                end
            end
            ST_STABLE: begin
                if (!ctl.lock)       state_d = ST_WAIT_LOCK;
                else if (stable_done) state_d = ST_HOLD;
            end
            ST_HOLD: begin
                if (!ctl.lock)     state_d = ST_WAIT_LOCK;
                else if (hold_done) state_d = ST_RUN;
            end
            ST_RUN: begin
                if (!ctl.lock) state_d = ST_POR;
            end
            ST_FAULT: begin
                state_d = ST_FAULT;
            end
            default: begin
                state_d = ST_POR;
            end
        endcase
    end

    always_comb begin
        cnt_d = cnt_q + CNT_W'(1);
        if (state_d != state_q) begin
            cnt_d = '0;
        end else if (state_q == ST_RUN || state_q == ST_FAULT) begin
            cnt_d = cnt_q;
        end
    end

    always_comb begin
        retry_d = retry_q;
        if (state_q == ST_WAIT_LOCK && !ctl.lock && timeout) begin
            retry_d = retry_inc;
        end else if (state_d == ST_RUN && state_q != ST_RUN) begin
            retry_d = '0;
        end
    end

    // Outputs decode the next state so they change on the transition edge.
    always_comb begin
        areset_d    = (state_d == ST_POR) || (state_d == ST_FAULT);
        soc_rst_n_d = state_d == ST_RUN;
        fault_d     = state_d == ST_FAULT;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q       <= '0;
            retry_q     <= '0;
            areset_q    <= 1'b1;
            soc_rst_n_q <= 1'b0;
            fault_q     <= 1'b0;
        end else begin
            cnt_q       <= cnt_d;
            retry_q     <= retry_d;
            areset_q    <= areset_d;
            soc_rst_n_q <= soc_rst_n_d;
            fault_q     <= fault_d;
        end
    end

`ifdef PLL_SEQ_LOCK_LOSS_CNT_EN
    logic [LOCK_LOSS_CNT_W-1:0] loss_q, loss_d;

    always_comb begin
        loss_d = loss_q;
        if (state_q == ST_RUN && !ctl.lock && loss_q != LOCK_LOSS_MAX) begin
            loss_d = loss_q + LOCK_LOSS_CNT_W'(1);
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            loss_q <= '0;
        end else begin
            loss_q <= loss_d;
        end
    end

    assign ctl.loss_cnt = loss_q;
`else
    assign ctl.loss_cnt = '0;
`endif

    assign ctl.state     = state_q;
    assign ctl.areset    = areset_q;
    assign ctl.soc_rst_n = soc_rst_n_q;
    assign ctl.fault     = fault_q;

endmodule

// File: rtl/pll_lock_reset_seq_sync_2ff.sv
// sync_2ff: two-flop synchronizer, asynchronous active-low reset to 0.
module sync_2ff (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic d_i,
    output logic q_o
);

    logic meta_q;
    logic sync_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            meta_q <= 1'b0;
            sync_q <= 1'b0;
        end else begin
            meta_q <= d_i;
            sync_q <= meta_q;
        end
    end

    assign q_o = sync_q;

endmodule

// File: rtl/pll_lock_reset_seq.sv
// pll_lock_reset_seq: PLL power-up/lock qualification and SoC reset release.
// Optional macro PLL_SEQ_LOCK_LOSS_CNT_EN enables the LOCK_LOSS_CNT register.
module pll_lock_reset_seq
    import pll_seq_pkg::*;
#(
    parameter int unsigned POR_CYCLES          = 128,
    parameter int unsigned LOCK_TIMEOUT_CYCLES = 65536,
    parameter int unsigned LOCK_STABLE_CYCLES  = 1024,
    parameter int unsigned SOC_HOLD_CYCLES     = 16,
    parameter int unsigned MAX_RETRIES         = 3
) (
    input  logic                       EXT_CLK_50MHz,
    input  logic                       BTN_RESET_n,
    input  logic                       PLL_LOCKED,
    output logic                       PLL_ARESET,
    output logic                       SOC_RESET_n,
    output logic [SEQ_STATE_W-1:0]     SEQ_STATE,
    output logic [LOCK_LOSS_CNT_W-1:0] LOCK_LOSS_CNT,
    output logic                       FAULT
);

    pll_seq_if ctl ();

    logic lock_s;
    logic sync_rst_n;

    // Lock from a PLL held in reset is meaningless; restart the synchronizer.
    assign sync_rst_n = BTN_RESET_n & ~ctl.areset;

    sync_2ff u_sync (
        .clk_i  (EXT_CLK_50MHz),
        .rst_ni (sync_rst_n),
        .d_i    (PLL_LOCKED),
        .q_o    (lock_s)
    );

    assign ctl.lock = lock_s;

    pll_lock_reset_seq_fsm #(
        .POR_CYCLES          (POR_CYCLES),
        .LOCK_TIMEOUT_CYCLES (LOCK_TIMEOUT_CYCLES),
        .LOCK_STABLE_CYCLES  (LOCK_STABLE_CYCLES),
        .SOC_HOLD_CYCLES     (SOC_HOLD_CYCLES),
        .MAX_RETRIES         (MAX_RETRIES)
    ) u_fsm (
        .clk_i  (EXT_CLK_50MHz),
        .rst_ni (BTN_RESET_n),
        .ctl    (ctl)
    );

    assign PLL_ARESET    = ctl.areset;
    assign SOC_RESET_n   = ctl.soc_rst_n;
    assign SEQ_STATE     = ctl.state;
    assign LOCK_LOSS_CNT = ctl.loss_cnt;
    assign FAULT         = ctl.fault;

endmodule

// File: tb/tb_pll_lock_reset_seq.sv
// tb_pll_lock_reset_seq: directed sequence with an expected-value scoreboard.
module tb_pll_lock_reset_seq;
    import pll_seq_pkg::*;

    typedef struct {
        string       tag;
        logic [13:0] v;
    } exp_t;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   vectors = 0;
    int   errs    = 0;
    int   loss_m  = 0;
    bit   ok;
    exp_t exp_q[$];

    pll_seq_if bus ();

    pll_lock_reset_seq #(
        .POR_CYCLES          (8),
        .LOCK_TIMEOUT_CYCLES (64),
        .LOCK_STABLE_CYCLES  (16),
        .SOC_HOLD_CYCLES     (4),
        .MAX_RETRIES         (2)
    ) dut (
        .EXT_CLK_50MHz (clk),
        .BTN_RESET_n   (rst_n),
        .PLL_LOCKED    (bus.lock),
        .PLL_ARESET    (bus.areset),
        .SOC_RESET_n   (bus.soc_rst_n),
        .SEQ_STATE     (bus.state),
        .LOCK_LOSS_CNT (bus.loss_cnt),
        .FAULT         (bus.fault)
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] llc_exp();
`ifdef PLL_SEQ_LOCK_LOSS_CNT_EN
        return (loss_m > 255) ? 8'hFF : 8'(loss_m);
`else
        return 8'h00;
`endif
    endfunction

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic push(input string tag, input logic [2:0] st,
                        input logic ar, input logic sr, input logic flt);
        exp_t e;
        e.tag = tag;
        e.v   = {st, ar, sr, flt, llc_exp()};
        exp_q.push_back(e);
    endtask

    task automatic chk();
        exp_t        e;
        logic [13:0] obs;
        vectors++;
        if (exp_q.size() == 0) begin
            errs++;
            $error("FAIL scoreboard: observed empty queue, required an entry");
            return;
        end
        e   = exp_q.pop_front();
        obs = {bus.state, bus.areset, bus.soc_rst_n, bus.fault, bus.loss_cnt};
        assert (obs === e.v) else begin
            errs++;
            $error("FAIL %s: observed st=%0d ar=%b sr=%b f=%b llc=%0d, required st=%0d ar=%b sr=%b f=%b llc=%0d",
                   e.tag, obs[13:11], obs[10], obs[9], obs[8], obs[7:0],
                   e.v[13:11], e.v[10], e.v[9], e.v[8], e.v[7:0]);
        end
    endtask

    task automatic wait_run(input int budget, output bit hit);
        hit = 1'b0;
        for (int k = 0; k < budget; k++) begin
            step(1);
            if (bus.state == 3'd4) begin
                hit = 1'b1;
                return;
            end
        end
        vectors++;
        errs++;
        $error("FAIL wait_run: observed state %0d, required 4 within %0d cycles",
               bus.state, budget);
    endtask

    initial begin
        #1ms;
        $display("FAIL watchdog: observed no finish, required finish before 1ms");
        $fatal(1);
    end

    initial begin
        bus.lock = 1'b1;
        rst_n    = 1'b0;
        step(3);
        push("reset", 0, 1, 0, 0); chk();

        // Nominal release with lock already high
        @(negedge clk); rst_n = 1'b1;
        step(7);  push("por_e7", 0, 1, 0, 0); chk();
        step(1);  push("areset_e8", 1, 0, 0, 0); chk();
        step(2);  push("wait_e10", 1, 0, 0, 0); chk();
        step(1);  push("stable_e11", 2, 0, 0, 0); chk();
        step(19); push("hold_e30", 3, 0, 0, 0); chk();
        step(1);  push("run_e31", 4, 0, 1, 0); chk();

        // Lock loss in RUN
        bus.lock = 1'b0;
        push("loss_e2", 4, 0, 1, 0);
        loss_m++;
        push("loss_e3", 0, 1, 0, 0);
        step(2); chk();
        step(1); chk();
        bus.lock = 1'b1;
        step(8);  push("reloss_wait", 1, 0, 0, 0); chk();
        step(3);  push("reloss_stable", 2, 0, 0, 0); chk();
        step(20); push("reloss_run", 4, 0, 1, 0); chk();

        // Stability restart
        rst_n = 1'b0; loss_m = 0;
        #1; push("async_reset_run", 0, 1, 0, 0); chk();
        @(negedge clk); rst_n = 1'b1;
        step(21); push("stable_cnt10", 2, 0, 0, 0); chk();
        bus.lock = 1'b0;
        step(1);
        bus.lock = 1'b1;
        step(1);  push("glitch_e23", 2, 0, 0, 0); chk();
        step(1);  push("glitch_wait", 1, 0, 0, 0); chk();
        step(1);  push("glitch_restable", 2, 0, 0, 0); chk();
        step(19); push("glitch_hold", 3, 0, 0, 0); chk();
        step(1);  push("glitch_run", 4, 0, 1, 0); chk();

        // Lock-loss counter saturation
        for (int i = 1; i <= 260; i++) begin
            bus.lock = 1'b0;
            step(3);
            loss_m++;
            bus.lock = 1'b1;
            wait_run(60, ok);
            if (!ok) break;
            if (i == 1 || i == 254 || i == 255 || i == 256 || i == 260) begin
                push($sformatf("sat_%0d", i), 4, 0, 1, 0); chk();
            end
        end

        // Reset asserted mid-HOLD
        rst_n = 1'b0; loss_m = 0;
        step(1);
        @(negedge clk); rst_n = 1'b1;
        step(28); push("hold_e28", 3, 0, 0, 0); chk();
        #2; rst_n = 1'b0;
        #1; push("async_reset_hold", 0, 1, 0, 0); chk();

        // Fault after two timeouts
        bus.lock = 1'b0;
        @(negedge clk); rst_n = 1'b1;
        step(71); push("to1_e71", 1, 0, 0, 0); chk();
        step(1);  push("to1_e72", 0, 1, 0, 0); chk();
        step(8);  push("retry_e80", 1, 0, 0, 0); chk();
        step(63); push("to2_e143", 1, 0, 0, 0); chk();
        step(1);  push("fault_e144", 5, 1, 0, 1); chk();
        bus.lock = 1'b1;
        step(100); push("fault_sticky", 5, 1, 0, 1); chk();
        rst_n = 1'b0;
        #1; push("fault_clear", 0, 1, 0, 0); chk();

        // Lock arriving on the timeout edge wins
        bus.lock = 1'b0;
        @(negedge clk); rst_n = 1'b1;
        step(69);
        bus.lock = 1'b1;
        step(2);  push("race_e71", 1, 0, 0, 0); chk();
        step(1);  push("race_e72", 2, 0, 0, 0); chk();
        step(20); push("race_run", 4, 0, 1, 0); chk();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
        $finish;
    end

endmodule

// File: doc/pll_lock_reset_seq.md
# pll_lock_reset_seq

Reset sequencer that sits opposite the PLL's reset/lock handshake on the DE0-Nano SoC top. It drives the PLL's active-high asynchronous reset through a power-up hold, then reads back the PLL lock output. It qualifies lock for a stable interval and releases a synchronous, active-low SoC reset. It re-sequences on lock loss and latches a fault after repeated lock failures.

## Interface
Parameters:
- POR_CYCLES, 128: cycles PLL_ARESET is held after reset release.
- LOCK_TIMEOUT_CYCLES, 65536: maximum cycles to wait for lock before a PLL retry.
- LOCK_STABLE_CYCLES, 1024: consecutive synchronized-lock cycles required before release.
- SOC_HOLD_CYCLES, 16: extra cycles SOC_RESET_n stays low after lock qualifies.
- MAX_RETRIES, 3: lock timeouts tolerated before FAULT (range 1..15).

Ports:
- EXT_CLK_50MHz  in  1  sole clock; external 50 MHz reference, never the PLL output.
- BTN_RESET_n  in  1  reset: one clock; reset is asynchronous and active-low.
- PLL_LOCKED  in  1  PLL lock, asynchronous to EXT_CLK_50MHz.
- PLL_ARESET  out  1  PLL reset, active-high, registered.
- SOC_RESET_n  out  1  SoC reset, active-low, registered; deassertion synchronous to EXT_CLK_50MHz.
- SEQ_STATE  out  3  current state encoding.
- LOCK_LOSS_CNT  out  8  saturating count of lock losses while in RUN.
- FAULT  out  1  sticky lock-failure flag.

## Operation
- PLL_LOCKED passes through a 2-FF synchronizer (lock_s). All FSM decisions use lock_s only.
- State encodings: POR=0, WAIT_LOCK=1, STABLE=2, HOLD=3, RUN=4, FAULT=5.
- POR: PLL_ARESET=1, SOC_RESET_n=0. Counts POR_CYCLES cycles, then goes to WAIT_LOCK.
- WAIT_LOCK: PLL_ARESET=0, SOC_RESET_n=0.
  - lock_s=1 goes to STABLE.
  - After LOCK_TIMEOUT_CYCLES without lock, retry_cnt increments. If the new value equals MAX_RETRIES, go to FAULT; otherwise go to POR.
- STABLE: counts consecutive lock_s=1 cycles. Reaching LOCK_STABLE_CYCLES goes to HOLD. lock_s=0 goes to WAIT_LOCK with the counter cleared and retry_cnt unchanged.
- HOLD: counts SOC_HOLD_CYCLES, then goes to RUN. lock_s=0 goes to WAIT_LOCK.
- RUN: SOC_RESET_n=1, and retry_cnt clears on entry. lock_s=0 goes to POR, LOCK_LOSS_CNT increments (saturating at 255), and SOC_RESET_n drops on that same edge.
- FAULT: PLL_ARESET=1, SOC_RESET_n=0, FAULT=1. The only exit is BTN_RESET_n.
- Reset values: PLL_ARESET=1, SOC_RESET_n=0, SEQ_STATE=0, LOCK_LOSS_CNT=0, FAULT=0, all counters 0. Reset asserted mid-sequence immediately forces these values asynchronously.
- One shared cycle counter is used across states and cleared on every state transition. It is sized to hold the largest parameter.

## Timing
- All outputs are registered, with no combinational path from any input to any output.
- PLL_LOCKED to lock_s latency: 2 cycles. The FSM reacts on the next edge, for 3 edges total from the input change to an output change.
- Rising edge of BTN_RESET_n = edge 1. PLL_ARESET falls on edge POR_CYCLES.
- Minimum reset-release to SOC_RESET_n rise: POR_CYCLES + 3 + LOCK_STABLE_CYCLES + SOC_HOLD_CYCLES edges, when PLL_LOCKED is already high.
- A lock glitch of one cycle or longer that reaches lock_s in STABLE or HOLD restarts qualification. Glitches shorter than one clock may be missed; this is acceptable.
- The timeout decision and a lock_s rise on the same edge: lock wins, and the FSM goes to STABLE.
- LOCK_LOSS_CNT holds at 255 and never wraps.

## Configuration
- PLL_SEQ_LOCK_LOSS_CNT_EN defined: the LOCK_LOSS_CNT register and its increment logic are built.
- Not defined: LOCK_LOSS_CNT is tied to 8'h00, the register is removed, and FSM behaviour is unchanged.

## Structure
- Package pll_seq_pkg holds:
  - the state enum with the fixed encodings above;
  - SEQ_STATE_W=3 and LOCK_LOSS_CNT_W=8;
  - LOCK_LOSS_MAX=8'hFF.
- Sub-module sync_2ff (1-bit, async active-low reset to 0) synchronizes PLL_LOCKED.

## Test plan
Sim parameters: POR_CYCLES=8, LOCK_TIMEOUT_CYCLES=64, LOCK_STABLE_CYCLES=16, SOC_HOLD_CYCLES=4, MAX_RETRIES=2.
- Nominal: PLL_LOCKED tied high, BTN_RESET_n released → PLL_ARESET falls on edge 8, SOC_RESET_n rises on edge 31, SEQ_STATE=4.
- Stability restart: PLL_LOCKED drops 1 cycle at STABLE count 10 → SEQ_STATE goes 2→1→2, and the full 16-cycle count restarts; SOC_RESET_n rises 16+4 cycles after re-entering STABLE.
- Lock loss in RUN: drop PLL_LOCKED → SOC_RESET_n=0 and PLL_ARESET=1 on the 3rd edge, LOCK_LOSS_CNT=1, SEQ_STATE=0. With lock restored, RUN is reached again.
- Fault: PLL_LOCKED held low → FAULT=1 after 2 timeouts, at edge 8+64+8+64, with PLL_ARESET=1. Only BTN_RESET_n clears it.
- Saturation (macro defined): force 260 RUN lock losses → LOCK_LOSS_CNT=255. With the macro undefined → LOCK_LOSS_CNT=0 throughout.
- Reset mid-HOLD: assert BTN_RESET_n → all outputs take their reset values without waiting for a clock edge.
